// File: rtl/proc_fetch_unit.sv
// Multi-outstanding instruction fetch stage: PC, imem val/rdy requests, pc-tag FIFO,
// instruction buffer and squash-drop counter. Optional perf counters: PROC_FETCH_PERF_EN.
module proc_fetch_unit #(
  parameter logic [31:0] p_reset_vector = 32'h200,
  parameter int          p_max_inflight = 2,
  parameter int          p_ibuf_depth   = 2
)(
  input  logic        clk,
  input  logic        reset_n,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_addr,
  input  logic        imemresp_val,
  output logic        imemresp_rdy,
  input  logic [31:0] imemresp_data,
  input  logic        redirect_val,
  input  logic [31:0] redirect_target,
  output logic        inst_val,
  input  logic        inst_rdy,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [3:0]  inflight
`ifdef PROC_FETCH_PERF_EN
  ,
  output logic [31:0] perf_squash_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int TW = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
  localparam int BW = (p_ibuf_depth > 1) ? $clog2(p_ibuf_depth) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ibuf_ent_t;

  logic [31:0]   pc_q, pc_d;
  logic [3:0]    inflight_q, inflight_d;
  logic [3:0]    drop_q, drop_d;
  logic [TW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [BW-1:0] ib_wr_q, ib_wr_d, ib_rd_q, ib_rd_d;
  logic [3:0]    ib_cnt_q, ib_cnt_d;
  logic [31:0]   tag_mem_q [p_max_inflight];
  ibuf_ent_t     ibuf_q    [p_ibuf_depth];

  logic [4:0] occ;
  logic       req_fire, resp_fire, drop_resp, ib_push, ib_pop;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(p_max_inflight - 1)) ? '0 : p + TW'(1);
  endfunction

  function automatic logic [BW-1:0] ib_next(input logic [BW-1:0] p);
    return (p == BW'(p_ibuf_depth - 1)) ? '0 : p + BW'(1);
  endfunction

  // Buffer slots already claimed by queued or live in-flight instructions
  assign occ = {1'b0, ib_cnt_q} + {1'b0, inflight_q} - {1'b0, drop_q};

  assign imemreq_val  = reset_n && !redirect_val && (inflight_q < 4'(p_max_inflight)) &&
                        (occ < 5'(p_ibuf_depth));
  assign imemreq_addr = pc_q;
  assign imemresp_rdy = reset_n;
  assign inflight     = inflight_q;
  assign inst_val     = reset_n && (ib_cnt_q != 4'd0);
  assign inst_data    = ibuf_q[ib_rd_q].inst;
  assign inst_pc      = ibuf_q[ib_rd_q].pc;

  // Responses with no outstanding tag (e.g. stale after reset) are ignored
  assign req_fire  = imemreq_val && imemreq_rdy;
  assign resp_fire = reset_n && imemresp_val && (inflight_q != 4'd0);
  assign drop_resp = resp_fire && ((drop_q != 4'd0) || redirect_val);
  assign ib_push   = resp_fire && (drop_q == 4'd0) && !redirect_val;
  assign ib_pop    = inst_val && inst_rdy && !redirect_val;

  always_comb begin
    pc_d       = pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + 4'(req_fire) - 4'(resp_fire);
    tag_wr_d   = req_fire  ? tag_next(tag_wr_q) : tag_wr_q;
    tag_rd_d   = resp_fire ? tag_next(tag_rd_q) : tag_rd_q;
    ib_wr_d    = ib_push ? ib_next(ib_wr_q) : ib_wr_q;
    ib_rd_d    = ib_pop  ? ib_next(ib_rd_q) : ib_rd_q;
    ib_cnt_d   = ib_cnt_q + 4'(ib_push) - 4'(ib_pop);
    if (redirect_val) begin
      pc_d     = redirect_target;
      drop_d   = inflight_q - 4'(resp_fire);
      ib_wr_d  = '0;
      ib_rd_d  = '0;
      ib_cnt_d = '0;
    end else begin
      if (req_fire)  pc_d   = pc_q + 32'd4;
      if (drop_resp) drop_d = drop_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q       <= p_reset_vector;
      inflight_q <= '0;
      drop_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      ib_wr_q    <= '0;
      ib_rd_q    <= '0;
      ib_cnt_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      ib_wr_q    <= ib_wr_d;
      ib_rd_q    <= ib_rd_d;
      ib_cnt_q   <= ib_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem_q[tag_wr_q] <= pc_q;
    if (ib_push)  ibuf_q[ib_wr_q]     <= '{pc: tag_mem_q[tag_rd_q], inst: imemresp_data};
  end

`ifdef PROC_FETCH_PERF_EN
  logic [31:0] squash_q, squash_d, stall_q, stall_d;

  assign squash_d        = squash_q + 32'(drop_resp);
  assign stall_d         = stall_q + 32'(inst_rdy && !inst_val && !redirect_val);
  assign perf_squash_cnt = squash_q;
  assign perf_stall_cnt  = stall_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      squash_q <= '0;
      stall_q  <= '0;
    end else begin
      squash_q <= squash_d;
      stall_q  <= stall_d;
    end
  end
`endif

`ifndef SYNTHESIS
  // Until the first post-reset request, leftover responses are legal and ignored
  logic after_rst_q;
  always_ff @(posedge clk) begin
    if (!reset_n)      after_rst_q <= 1'b1;
    else if (req_fire) after_rst_q <= 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset_n && !after_rst_q)
      assert (!(imemresp_val && inflight_q == 4'd0))
        else $error("imem response with no outstanding request");
  end
`endif

endmodule

// File: tb/tb_proc_fetch_unit.sv
// Directed bench for proc_fetch_unit with a 1-cycle imem model and an expected-PC scoreboard.
module tb_proc_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_n, imemreq_val, imemreq_rdy, imemresp_val, imemresp_rdy;
  logic        redirect_val, inst_val, inst_rdy;
  logic [31:0] imemreq_addr, imemresp_data, redirect_target, inst_data, inst_pc;
  logic [3:0]  inflight;
`ifdef PROC_FETCH_PERF_EN
  logic [31:0] perf_squash_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  proc_fetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
    .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy), .imemresp_data(imemresp_data),
    .redirect_val(redirect_val), .redirect_target(redirect_target),
    .inst_val(inst_val), .inst_rdy(inst_rdy), .inst_data(inst_data), .inst_pc(inst_pc),
    .inflight(inflight)
`ifdef PROC_FETCH_PERF_EN
    , .perf_squash_cnt(perf_squash_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int          tests = 0, fails = 0, pops = 0;
  logic [31:0] exp_q[$], mem_q[$], issued_q[$];
  logic [31:0] exp_pc, first_pc, seen_addr, pc_e;
  logic        mem_en, seen_req;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a ^ 32'h1357_9BDF) + 32'h11;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory, check combinational outputs, update model, advance.
  task automatic tick();
    imemresp_val  = mem_en && (mem_q.size() > 0);
    imemresp_data = (mem_q.size() > 0) ? memfn(mem_q[0]) : 32'h0;
    #1;
    seen_req  = imemreq_val;
    seen_addr = imemreq_addr;
    if (!reset_n) begin
      check("rst_req_val", 32'(imemreq_val), 32'd0);
      check("rst_inst_val", 32'(inst_val), 32'd0);
      check("rst_resp_rdy", 32'(imemresp_rdy), 32'd0);
    end else begin
      if (redirect_val) check("redir_noreq", 32'(imemreq_val), 32'd0);
      else if (imemreq_val) check("req_addr", imemreq_addr, exp_pc);
      if (inst_val && inst_rdy && !redirect_val) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          pc_e = exp_q.pop_front();
          check("inst_pc", inst_pc, pc_e);
          check("inst_data", inst_data, memfn(pc_e));
        end
        if (pops == 0) first_pc = inst_pc;
        pops++;
      end
    end
    if (imemresp_val) void'(mem_q.pop_front());
    if (!reset_n) begin
      exp_q.delete();
      exp_pc = 32'h200;
    end else if (redirect_val) begin
      exp_q.delete();
      exp_pc = redirect_target;
    end else if (imemreq_val && imemreq_rdy) begin
      exp_q.push_back(exp_pc);
      mem_q.push_back(imemreq_addr);
      issued_q.push_back(imemreq_addr);
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mem_en  = 1'b0;
    mem_q.delete();
    tick();
    reset_n = 1'b1;
    issued_q.delete();
    pops = 0;
  endtask

  initial begin
    reset_n = 1'b0; imemreq_rdy = 1'b1; imemresp_val = 1'b0; imemresp_data = '0;
    redirect_val = 1'b0; redirect_target = '0; inst_rdy = 1'b0; mem_en = 1'b0;
    exp_pc = 32'h200; first_pc = '0; pc_e = '0;
    @(negedge clk);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check("post_rst_inflight", 32'(inflight), 32'd0);
    check("post_rst_resp_rdy", 32'(imemresp_rdy), 32'd1);
    check("post_rst_addr", imemreq_addr, 32'h200);
    #1;

    // 1: free-running fetch with always-ready memory
    issued_q.delete(); pops = 0;
    inst_rdy = 1'b1; mem_en = 1'b1;
    repeat (20) tick();
    check("t1_addr0", issued_q[0], 32'h200);
    check("t1_addr1", issued_q[1], 32'h204);
    check("t1_addr2", issued_q[2], 32'h208);
    check("t1_first_pc", first_pc, 32'h200);
    check("t1_throughput", 32'(pops >= 10), 32'd1);

    // 2: D stalled, buffer fills, then drains with no lost or duplicated PCs
    do_reset();
    inst_rdy = 1'b0; mem_en = 1'b1;
    repeat (8) tick();
    #1;
    check("t2_issued", 32'(issued_q.size()), 32'd2);
    check("t2_inst_val", 32'(inst_val), 32'd1);
    check("t2_req_blocked", 32'(imemreq_val), 32'd0);
    #1;
    inst_rdy = 1'b1;
    repeat (10) tick();
    check("t2_first_pc", first_pc, 32'h200);
    check("t2_resume_addr", issued_q[2], 32'h208);

    // 3: redirect with two requests outstanding
    do_reset();
    inst_rdy = 1'b1; mem_en = 1'b0;
    repeat (2) tick();
    check("t3_inflight", 32'(inflight), 32'd2);
    redirect_val = 1'b1; redirect_target = 32'h400;
    tick();
    redirect_val = 1'b0;
    check("t3_inflight_after", 32'(inflight), 32'd2);
    pops = 0; mem_en = 1'b1;
    repeat (8) tick();
    check("t3_first_pc", first_pc, 32'h400);
`ifdef PROC_FETCH_PERF_EN
    check("t3_squash_cnt", perf_squash_cnt, 32'd2);
`endif

    // 4: redirect coincident with the 0x204 response, 0x208 still outstanding
    do_reset();
    inst_rdy = 1'b1; mem_en = 1'b0;
    repeat (2) tick();
    mem_en = 1'b1;
    tick();
    mem_en = 1'b0;
    for (int i = 0; i < 5 && inflight != 4'd2; i++) tick();
    check("t4_two_out", 32'(inflight), 32'd2);
    check("t4_third_addr", issued_q[2], 32'h208);
    check("t4_head_resp", mem_q[0], 32'h204);
    redirect_val = 1'b1; redirect_target = 32'h400; mem_en = 1'b1;
    tick();
    redirect_val = 1'b0;
    check("t4_inflight", 32'(inflight), 32'd1);
    pops = 0;
    tick();
    check("t4_next_req", 32'(seen_req), 32'd1);
    check("t4_next_addr", seen_addr, 32'h400);
    repeat (6) tick();
    check("t4_first_pc", first_pc, 32'h400);

    // 5: wrap of the PC at the top of the address space
    do_reset();
    inst_rdy = 1'b1; mem_en = 1'b1;
    redirect_val = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_val = 1'b0;
    repeat (8) tick();
    check("t5_addr0", issued_q[0], 32'hFFFF_FFFC);
    check("t5_addr1", issued_q[1], 32'h0000_0000);
    check("t5_addr2", issued_q[2], 32'h0000_0004);
    check("t5_first_pc", first_pc, 32'hFFFF_FFFC);

    // 6: reset mid-stream with two requests outstanding; stale responses ignored
    do_reset();
    inst_rdy = 1'b0; mem_en = 1'b0;
    repeat (2) tick();
    check("t6_inflight", 32'(inflight), 32'd2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check("t6_rst_inflight", 32'(inflight), 32'd0);
    check("t6_rst_inst_val", 32'(inst_val), 32'd0);
    check("t6_rst_addr", imemreq_addr, 32'h200);
    #1;
    imemreq_rdy = 1'b0; mem_en = 1'b1;
    repeat (2) tick();
    check("t6_stale_inst_val", 32'(inst_val), 32'd0);
    check("t6_stale_inflight", 32'(inflight), 32'd0);
    pops = 0; issued_q.delete();
    imemreq_rdy = 1'b1; inst_rdy = 1'b1;
    repeat (8) tick();
    check("t6_first_pc", first_pc, 32'h200);
    check("t6_first_addr", issued_q[0], 32'h200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
